// File: rtl/ysyx_25030077_clint.sv
// ysyx_25030077_clint
// Core-local timer read responder on the clint side of the crossbar.
// Holds a free-running 64-bit mtime with a programmable prescaler. It answers
// single-beat AXI-lite style reads of the low word (BASE) and the high word
// (BASE+4). Reading the low word snapshots the high word, so a low-then-high
// pair of 32-bit reads always returns one coherent 64-bit value.
//
// Ports:
//   clock, reset       system clock, synchronous active-high reset
//   io_axi_ar_*        read address channel (strb accepted but ignored)
//   io_axi_r_*         read data channel; r_data is zero whenever r_valid is low
//   io_axi_b_*         write response channel, tied inactive (b_ready ignored)
//
// Parameters:
//   DIV       clock cycles per mtime increment (>= 1)
//   RD_DELAY  extra cycles between the AR handshake and r_valid (0..15)
//   BASE      address of the mtime low word
module ysyx_25030077_clint #(
    parameter int unsigned DIV      = 1,
    parameter int unsigned RD_DELAY = 0,
    parameter logic [31:0] BASE     = 32'ha0000048
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_axi_ar_valid,
    input  logic [31:0] io_axi_ar_addr,
    input  logic [2:0]  io_axi_ar_strb,
    output logic        io_axi_ar_ready,
    output logic        io_axi_r_valid,
    output logic [31:0] io_axi_r_data,
    input  logic        io_axi_r_ready,
    output logic        io_axi_b_valid,
    input  logic        io_axi_b_ready,
    output logic [1:0]  io_axi_b_resp
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [63:0]    mtime;
    logic [PW-1:0]  presc;
    logic [31:0]    snap;
    logic           snap_valid;
    logic [31:0]    rdata_q;
    logic [3:0]     dly;
    logic           ar_fire;
    logic           r_fire;
    logic           tick;
    logic           is_lo;
    logic           is_hi;
    logic           unused_ok;

    // Response word for an accepted read, using mtime as it stands in the
    // handshake cycle (before this cycle's increment).
    function automatic logic [31:0] resp_word(
        input logic [31:0] addr,
        input logic [63:0] mt,
        input logic        sv,
        input logic [31:0] sn
    );
        logic [31:0] w;
        w = 32'h0;
        if (addr == BASE) begin
            w = mt[31:0];
        end else if (addr == BASE + 32'd4) begin
            w = sv ? sn : mt[63:32];
        end
        return w;
    endfunction

    assign unused_ok = ^{io_axi_ar_strb, io_axi_b_ready};

    assign io_axi_ar_ready = (state == IDLE);
    assign io_axi_r_valid  = (state == RESP);
    assign io_axi_r_data   = (state == RESP) ? rdata_q : 32'h0;
    assign io_axi_b_valid  = 1'b0;
    assign io_axi_b_resp   = 2'h0;

    assign ar_fire = io_axi_ar_valid && io_axi_ar_ready;
    assign r_fire  = io_axi_r_valid && io_axi_r_ready;
    assign tick    = (presc == PW'(DIV - 1));
    assign is_lo   = (io_axi_ar_addr == BASE);
    assign is_hi   = (io_axi_ar_addr == BASE + 32'd4);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (ar_fire) begin
                    state_nxt = (RD_DELAY > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                // dly counts 0..RD_DELAY-1 while in WAIT
                if (dly == 4'(RD_DELAY - 1)) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (r_fire) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mtime      <= 64'h0;
            presc      <= '0;
            state      <= IDLE;
            snap_valid <= 1'b0;
            snap       <= 32'h0;
            rdata_q    <= 32'h0;
            dly        <= 4'h0;
        end else begin
            // mtime runs in every state, independent of bus activity
            if (tick) begin
                presc <= '0;
                mtime <= mtime + 64'd1;
            end else begin
                presc <= presc + PW'(1);
            end

            state <= state_nxt;

            if (state == WAIT) begin
                dly <= dly + 4'd1;
            end else begin
                dly <= 4'h0;
            end

            if (ar_fire) begin
                rdata_q <= resp_word(io_axi_ar_addr, mtime, snap_valid, snap);
                if (is_lo) begin
                    snap       <= mtime[63:32];
                    snap_valid <= 1'b1;
                end else if (is_hi) begin
                    snap_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ysyx_25030077_clint.sv
module tb_ysyx_25030077_clint;

    localparam logic [31:0] BASE  = 32'ha0000048;
    localparam logic [31:0] UNMAP = 32'ha0000050;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        ar_valid [2];
    logic [31:0] ar_addr  [2];
    logic [2:0]  ar_strb  [2];
    logic        ar_ready [2];
    logic        r_valid  [2];
    logic [31:0] r_data   [2];
    logic        r_ready  [2];
    logic        b_valid  [2];
    logic        b_ready  [2];
    logic [1:0]  b_resp   [2];

    int              checks   = 0;
    int              failures = 0;
    longint unsigned tick;
    logic [31:0]     exp_q [$];

    always #5 clk = ~clk;

    ysyx_25030077_clint #(.DIV(1), .RD_DELAY(0), .BASE(BASE)) dut_a (
        .clock(clk), .reset(rst),
        .io_axi_ar_valid(ar_valid[0]), .io_axi_ar_addr(ar_addr[0]),
        .io_axi_ar_strb(ar_strb[0]), .io_axi_ar_ready(ar_ready[0]),
        .io_axi_r_valid(r_valid[0]), .io_axi_r_data(r_data[0]),
        .io_axi_r_ready(r_ready[0]), .io_axi_b_valid(b_valid[0]),
        .io_axi_b_ready(b_ready[0]), .io_axi_b_resp(b_resp[0])
    );

    ysyx_25030077_clint #(.DIV(4), .RD_DELAY(3), .BASE(BASE)) dut_b (
        .clock(clk), .reset(rst),
        .io_axi_ar_valid(ar_valid[1]), .io_axi_ar_addr(ar_addr[1]),
        .io_axi_ar_strb(ar_strb[1]), .io_axi_ar_ready(ar_ready[1]),
        .io_axi_r_valid(r_valid[1]), .io_axi_r_data(r_data[1]),
        .io_axi_r_ready(r_ready[1]), .io_axi_b_valid(b_valid[1]),
        .io_axi_b_ready(b_ready[1]), .io_axi_b_resp(b_resp[1])
    );

    // Cycles since reset release: equals the DIV=1 mtime value in the current cycle.
    always @(posedge clk) begin
        if (rst) tick <= 0;
        else     tick <= tick + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("b_valid", {b_valid[1], b_valid[0]}, 0);
            chk("b_resp", {b_resp[1], b_resp[0]}, 0);
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            ar_valid[d] = 1'b0;
            r_ready[d]  = 1'b0;
        end
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_tick(input longint unsigned n);
        while (tick < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One read on DUT d. The expected word is queued when the address is
    // driven and popped when r_valid appears. stall = cycles r_ready is held
    // low; abort = assert reset instead of completing the R handshake.
    task automatic rd(input int d, input logic [31:0] addr, input logic [31:0] exp,
                      input int lat_exp, input int stall, input bit abort);
        int          lat;
        logic [31:0] expv;
        chk("ar_ready_idle", ar_ready[d], 1);
        ar_valid[d] = 1'b1;
        ar_addr[d]  = addr;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        ar_valid[d] = 1'b0;
        lat = 1;
        while (!r_valid[d] && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("r_latency", lat, lat_exp);
        if (!r_valid[d]) begin
            exp_q.delete();
            return;
        end
        expv = exp_q.pop_front();
        chk("r_data", r_data[d], expv);
        chk("ar_ready_busy", ar_ready[d], 0);
        if (abort) begin
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
            chk("rst_r_valid", r_valid[d], 0);
            chk("rst_ar_ready", ar_ready[d], 1);
            chk("rst_mtime", (d == 0) ? dut_a.mtime : dut_b.mtime, 0);
            return;
        end
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            chk("hold_r_valid", r_valid[d], 1);
            chk("hold_r_data", r_data[d], expv);
            chk("hold_ar_ready", ar_ready[d], 0);
        end
        r_ready[d] = 1'b1;
        @(posedge clk);
        #1;
        r_ready[d] = 1'b0;
        chk("post_r_valid", r_valid[d], 0);
        chk("post_r_data", r_data[d], 0);
        chk("post_ar_ready", ar_ready[d], 1);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            ar_valid[d] = 1'b0;
            ar_addr[d]  = 32'h0;
            ar_strb[d]  = 3'h2;
            r_ready[d]  = 1'b0;
            b_ready[d]  = 1'b1;
        end

        do_reset();
        for (int d = 0; d < 2; d++) begin
            chk("reset_ar_ready", ar_ready[d], 1);
            chk("reset_r_valid", r_valid[d], 0);
            chk("reset_r_data", r_data[d], 0);
        end
        chk("reset_mtime", dut_a.mtime, 0);
        chk("reset_snap_valid", dut_a.snap_valid, 0);

        // First read ten cycles after reset release
        wait_tick(10);
        rd(0, BASE, 32'd10, 1, 0, 1'b0);

        // Back-pressure on a low-word read
        rd(0, BASE, tick[31:0], 1, 5, 1'b0);

        // Coherent high word across a low-word carry
        step(1);
        force dut_a.mtime = 64'h0000_0000_ffff_fffe;
        #1;
        release dut_a.mtime;
        rd(0, BASE, 32'hffff_fffe, 1, 0, 1'b0);
        step(4);
        rd(0, UNMAP, 32'h0, 1, 0, 1'b0);
        chk("snap_kept_unmapped", dut_a.snap_valid, 1);
        rd(0, BASE + 32'd4, 32'h0, 1, 0, 1'b0);
        chk("snap_cleared", dut_a.snap_valid, 0);
        rd(0, BASE + 32'd4, 32'h1, 1, 0, 1'b0);

        // Prescaler DIV=4 with RD_DELAY=3
        do_reset();
        wait_tick(40);
        rd(1, BASE, 32'd10, 4, 0, 1'b0);
        do_reset();
        wait_tick(43);
        rd(1, BASE, 32'd10, 4, 0, 1'b0);
        do_reset();
        wait_tick(44);
        rd(1, BASE, 32'd11, 4, 2, 1'b0);
        rd(1, UNMAP, 32'h0, 4, 0, 1'b0);
        chk("b_snap_kept_unmapped", dut_b.snap_valid, 1);
        rd(1, BASE + 32'd4, 32'h0, 4, 0, 1'b0);
        chk("b_snap_cleared", dut_b.snap_valid, 0);

        // Reset while a response is pending, then a normal read afterwards
        do_reset();
        wait_tick(5);
        rd(0, BASE, 32'd5, 1, 0, 1'b1);
        step(3);
        rd(0, BASE, tick[31:0], 1, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
